// File: rtl/decode_scan_nto1hot.sv
// Registered binary-to-one-hot select decoder with a DIRECT (validated code) mode
// and a free-running SCAN mode that dwells TICK_DIV cycles on each output.
module decode_scan_nto1hot #(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned NUM_OUT  = 8,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned ACT_LOW  = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               pi_en,
  input  logic               pi_mode,
  input  logic               pi_valid,
  input  logic [SEL_W-1:0]   pi_data,
  output logic [NUM_OUT-1:0] po_data,
  output logic [SEL_W-1:0]   po_index,
  output logic               po_valid,
  output logic               po_err
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] IdxMax = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] Inact = (ACT_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [SEL_W-1:0]   idx_next;
  logic               code_ok;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = Inact ^ (NUM_OUT'(1) << idx);
  endfunction

  // One extra bit so NUM_OUT == 2**SEL_W compares correctly.
  assign code_ok  = ({1'b0, pi_data} < (SEL_W + 1)'(NUM_OUT));
  assign idx_next = (idx_q == IdxMax) ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (!pi_en) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = Inact;
    end else if (pi_mode) begin
      state_d = StScan;
      if (state_q != StScan) begin
        // Fresh entry always restarts at output 0 with a new dwell.
        cnt_d   = '0;
        idx_d   = '0;
        data_d  = onehot('0);
        valid_d = 1'b1;
      end else if (cnt_q == CntMax) begin
        cnt_d   = '0;
        idx_d   = idx_next;
        data_d  = onehot(idx_next);
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      state_d = StDirect;
      cnt_d   = '0;
      if (pi_valid) begin
        if (code_ok) begin
          idx_d   = pi_data;
          data_d  = onehot(pi_data);
          valid_d = 1'b1;
        end else begin
          data_d = Inact;
          err_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= Inact;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign po_data  = data_q;
  assign po_index = idx_q;
  assign po_valid = valid_q;
  assign po_err   = err_q;

endmodule

// File: tb/tb_decode_scan_nto1hot.sv
// Directed bench: four decoder variants share one stimulus set; each task checks the
// variant whose parameters exercise that feature.
module tb_decode_scan_nto1hot;

  logic       clk = 1'b0;
  logic       rst, en, mode, valid;
  logic [2:0] code;

  logic [7:0] a_data, c_data, d_data;
  logic [5:0] b_data;
  logic [2:0] a_idx, b_idx, c_idx, d_idx;
  logic       a_vld, b_vld, c_vld, d_vld;
  logic       a_err, b_err, c_err, d_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_scan_nto1hot #(.SEL_W(3), .NUM_OUT(8), .TICK_DIV(3), .ACT_LOW(0)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .pi_en(en), .pi_mode(mode), .pi_valid(valid),
    .pi_data(code), .po_data(a_data), .po_index(a_idx), .po_valid(a_vld), .po_err(a_err)
  );
  decode_scan_nto1hot #(.SEL_W(3), .NUM_OUT(6), .TICK_DIV(3), .ACT_LOW(0)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .pi_en(en), .pi_mode(mode), .pi_valid(valid),
    .pi_data(code), .po_data(b_data), .po_index(b_idx), .po_valid(b_vld), .po_err(b_err)
  );
  decode_scan_nto1hot #(.SEL_W(3), .NUM_OUT(8), .TICK_DIV(3), .ACT_LOW(1)) dut_c (
    .sys_clk(clk), .sys_rst(rst), .pi_en(en), .pi_mode(mode), .pi_valid(valid),
    .pi_data(code), .po_data(c_data), .po_index(c_idx), .po_valid(c_vld), .po_err(c_err)
  );
  decode_scan_nto1hot #(.SEL_W(3), .NUM_OUT(8), .TICK_DIV(1), .ACT_LOW(0)) dut_d (
    .sys_clk(clk), .sys_rst(rst), .pi_en(en), .pi_mode(mode), .pi_valid(valid),
    .pi_data(code), .po_data(d_data), .po_index(d_idx), .po_valid(d_vld), .po_err(d_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; valid = 1'b0; code = '0;
    tick();
    tick();
    checks++;
    if (a_data !== 8'h00 || a_idx !== 3'd0 || a_vld !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got data=%h idx=%0d vld=%b err=%b, want 00/0/0/0",
               a_data, a_idx, a_vld, a_err);
    end
    checks++;
    if (c_data !== 8'hFF || c_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_c: got data=%h idx=%0d, want ff/0", c_data, c_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct_sweep();
    logic [7:0] exp;
    en = 1'b1; mode = 1'b0;
    tick();
    checks++;
    if (a_data !== 8'h00 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_to_direct: got data=%h vld=%b, want 00/0", a_data, a_vld);
    end
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; code = 3'(i);
      exp = 8'h01 << i;
      tick();
      checks++;
      if (a_data !== exp || a_idx !== 3'(i) || a_vld !== 1'b1 || a_err !== 1'b0) begin
        errors++;
        $display("FAIL direct_code%0d: got data=%h idx=%0d vld=%b err=%b, want %h/%0d/1/0",
                 i, a_data, a_idx, a_vld, a_err, exp, i);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (a_data !== 8'h80 || a_idx !== 3'd7 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL direct_hold: got data=%h idx=%0d vld=%b, want 80/7/0", a_data, a_idx, a_vld);
    end
  endtask

  task automatic test_out_of_range();
    valid = 1'b1; code = 3'd3;
    tick();
    checks++;
    if (b_data !== 6'h08 || b_idx !== 3'd3 || b_vld !== 1'b1 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_setup: got data=%h idx=%0d vld=%b err=%b, want 08/3/1/0",
               b_data, b_idx, b_vld, b_err);
    end
    for (int c = 6; c < 8; c++) begin
      code = 3'(c);
      tick();
      checks++;
      if (b_data !== 6'h00 || b_idx !== 3'd3 || b_vld !== 1'b0 || b_err !== 1'b1) begin
        errors++;
        $display("FAIL oor_code%0d: got data=%h idx=%0d vld=%b err=%b, want 00/3/0/1",
                 c, b_data, b_idx, b_vld, b_err);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (b_err !== 1'b0 || b_data !== 6'h00) begin
      errors++;
      $display("FAIL oor_strobe: got err=%b data=%h, want 0/00", b_err, b_data);
    end
  endtask

  task automatic test_scan_wrap();
    logic [2:0] ei;
    valid = 1'b0; mode = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      ei = 3'((k / 3) % 8);
      checks++;
      if (a_idx !== ei || a_data !== (8'h01 << ei) || a_vld !== (k % 3 == 0) || a_err !== 1'b0)
      begin
        errors++;
        $display("FAIL scan_a_k%0d: got idx=%0d data=%h vld=%b err=%b, want %0d/%h/%b/0",
                 k, a_idx, a_data, a_vld, a_err, ei, 8'h01 << ei, k % 3 == 0);
      end
      ei = 3'(k % 8);
      checks++;
      if (d_idx !== ei || d_data !== (8'h01 << ei) || d_vld !== 1'b1) begin
        errors++;
        $display("FAIL scan_d_k%0d: got idx=%0d data=%h vld=%b, want %0d/%h/1",
                 k, d_idx, d_data, d_vld, ei, 8'h01 << ei);
      end
    end
  endtask

  task automatic test_interrupts();
    en = 1'b0;
    tick();
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (a_idx !== 3'd4 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL int_mid: got idx=%0d vld=%b, want 4/0", a_idx, a_vld);
    end
    en = 1'b0;
    tick();
    checks++;
    if (a_data !== 8'h00 || a_idx !== 3'd0 || a_vld !== 1'b0) begin
      errors++;
      $display("FAIL int_disable: got data=%h idx=%0d vld=%b, want 00/0/0", a_data, a_idx, a_vld);
    end
    en = 1'b1;
    tick();
    checks++;
    if (a_data !== 8'h01 || a_idx !== 3'd0 || a_vld !== 1'b1) begin
      errors++;
      $display("FAIL int_reenter: got data=%h idx=%0d vld=%b, want 01/0/1", a_data, a_idx, a_vld);
    end
    for (int k = 0; k < 13; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (a_data !== 8'h00 || a_idx !== 3'd0 || a_vld !== 1'b0 || c_data !== 8'hFF) begin
      errors++;
      $display("FAIL int_reset: got a=%h idx=%0d vld=%b c=%h, want 00/0/0/ff",
               a_data, a_idx, a_vld, c_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 1'b1; valid = 1'b0;
    tick();
    tick();
    mode = 1'b0; valid = 1'b1; code = 3'd6;
    tick();
    checks++;
    if (a_data !== 8'h40 || a_idx !== 3'd6 || a_vld !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_direct: got data=%h idx=%0d vld=%b, want 40/6/1",
               a_data, a_idx, a_vld);
    end
    tick();
    checks++;
    if (a_data !== 8'h40 || a_vld !== 1'b1) begin
      errors++;
      $display("FAIL b2b_repeat: got data=%h vld=%b, want 40/1", a_data, a_vld);
    end
    mode = 1'b1; valid = 1'b0;
    tick();
    checks++;
    if (a_data !== 8'h01 || a_idx !== 3'd0 || a_vld !== 1'b1) begin
      errors++;
      $display("FAIL b2b_to_scan: got data=%h idx=%0d vld=%b, want 01/0/1", a_data, a_idx, a_vld);
    end
  endtask

  task automatic test_act_low();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b0; valid = 1'b1; code = 3'd2;
    tick();
    checks++;
    if (c_data !== 8'hFB || c_idx !== 3'd2 || c_vld !== 1'b1) begin
      errors++;
      $display("FAIL al_direct2: got data=%h idx=%0d vld=%b, want fb/2/1", c_data, c_idx, c_vld);
    end
    valid = 1'b0; mode = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (c_data !== 8'hFB || c_idx !== 3'd2 || c_vld !== 1'b1) begin
      errors++;
      $display("FAIL al_scan_idx2: got data=%h idx=%0d vld=%b, want fb/2/1", c_data, c_idx, c_vld);
    end
    mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (c_data !== 8'hFB || c_idx !== 3'd2 || c_vld !== 1'b0) begin
        errors++;
        $display("FAIL al_hold%0d: got data=%h idx=%0d vld=%b, want fb/2/0",
                 k, c_data, c_idx, c_vld);
      end
    end
    valid = 1'b1; code = 3'd5;
    tick();
    checks++;
    if (c_data !== 8'hDF || c_idx !== 3'd5 || c_vld !== 1'b1) begin
      errors++;
      $display("FAIL al_direct5: got data=%h idx=%0d vld=%b, want df/5/1", c_data, c_idx, c_vld);
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_out_of_range();
    test_scan_wrap();
    test_interrupts();
    test_back_to_back();
    test_act_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
